// File: rtl/frontmon_pkg.sv
// Shared types and constants for the front-panel monitor capture path.
// MODECODE values must track the select decode in the monitor mux.
package frontmon_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PRE   = 3'd1,
        ST_ARMED = 3'd2,
        ST_POST  = 3'd3,
        ST_DONE  = 3'd4
    } capState_t;

    localparam logic [3:0] MC_FIFO_FE = 4'd1;
    localparam logic [3:0] MC_FIFO_FF = 4'd2;
    localparam logic [3:0] MC_FIFO_HF = 4'd3;
    localparam logic [3:0] MC_OE      = 4'd4;
    localparam logic [3:0] MC_REN     = 4'd5;
    localparam logic [3:0] MC_LCT_VLD = 4'd6;
    localparam logic [3:0] MC_LCT_Q   = 4'd7;
    localparam logic [3:0] MC_LCT_KEY = 4'd8;
    localparam logic [3:0] MC_ALCT    = 4'd9;
    localparam logic [3:0] MC_L1A     = 4'd10;
    localparam logic [3:0] MC_BXN     = 4'd11;
    localparam logic [3:0] MC_ERR     = 4'd12;
    localparam logic [3:0] MC_CFEB    = 4'd13;
    localparam logic [3:0] MC_TSTAT   = 4'd14;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/frontmon_capbuf.sv
// Snapshot buffer: DEPTH x 16 simple dual-port RAM, synchronous write and
// registered read, small enough to map onto distributed RAM.
module frontmon_capbuf
    import frontmon_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_rstB,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [15:0]   i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [15:0]   o_rdata
);

    logic [15:0] r_mem [DEPTH];
    logic [15:0] r_rdData;

    // The array carries no reset so it stays a plain RAM; stale contents are
    // never presented because reads are only issued from a completed capture.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstB) begin
            r_rdData <= '0;
        end else if (i_re) begin
            r_rdData <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdData;

endmodule

// File: rtl/frontmon_capture.sv
// Pre/post-trigger snapshot of the monitor mux output, frozen on a masked
// pattern edge or an external strobe, then read out oldest word first.
module frontmon_capture
    import frontmon_pkg::*;
#(
    parameter int TMR       = 0,
    parameter int DEPTH     = 16,
    parameter int POST_TRIG = 8
) (
    input  logic        i_clk,
    input  logic        i_rstB,
    input  logic [3:0]  i_modecode,
    input  logic [15:0] i_multout,
    input  logic        i_arm,
    input  logic        i_trigExt,
    input  logic [15:0] i_trigMask,
    input  logic [15:0] i_trigVal,
    input  logic        i_rdEn,
    output logic [15:0] o_rdData,
    output logic        o_rdVld,
    output logic        o_busy,
    output logic        o_ready,
    output logic        o_aborted,
    output logic [3:0]  o_trigMode
);

    localparam int AW    = clog2(DEPTH);
    localparam int CW    = AW + 1;
    localparam int NCOPY = (TMR != 0) ? 3 : 1;

    localparam logic [CW-1:0] PRE_LEN  = CW'(DEPTH - POST_TRIG - 1);
    localparam logic [CW-1:0] POST_LEN = CW'(POST_TRIG);
    localparam logic [CW-1:0] RD_LEN   = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [15:0] r_syncA;
    logic [15:0] r_syncB;
    logic [3:0]  r_modeA;
    logic [3:0]  r_modeB;
    logic        r_hitPrev;
    logic        r_extPrev;

    logic        w_hit;
    logic        w_trig;
    logic        w_modeChange;

    // MULTOUT mixes asynchronous FIFO flags, so it gets two flops; MODECODE is
    // already synchronous and only needs the second stage to stay aligned.
    always_ff @(posedge i_clk) begin
        if (!i_rstB) begin
            r_syncA   <= '0;
            r_syncB   <= '0;
            r_modeA   <= '0;
            r_modeB   <= '0;
            r_hitPrev <= 1'b0;
            r_extPrev <= 1'b0;
        end else begin
            r_syncA   <= i_multout;
            r_syncB   <= r_syncA;
            r_modeA   <= i_modecode;
            r_modeB   <= r_modeA;
            r_hitPrev <= w_hit;
            r_extPrev <= i_trigExt;
        end
    end

    assign w_hit        = (i_trigMask != 16'h0000) &&
                          (((r_syncB ^ i_trigVal) & i_trigMask) == 16'h0000);
    assign w_trig       = (w_hit && !r_hitPrev) || (i_trigExt && !r_extPrev);
    assign w_modeChange = (r_modeA != r_modeB);

    capState_t     r_state [NCOPY];
    logic [AW-1:0] r_wp    [NCOPY];
    logic [AW-1:0] r_rp    [NCOPY];

    capState_t     w_state;
    logic [AW-1:0] w_wp;
    logic [AW-1:0] w_rp;

    generate
        if (TMR != 0) begin : g_vote
            assign w_state = capState_t'((r_state[0] & r_state[1]) |
                                         (r_state[0] & r_state[2]) |
                                         (r_state[1] & r_state[2]));
            assign w_wp    = (r_wp[0] & r_wp[1]) | (r_wp[0] & r_wp[2]) | (r_wp[1] & r_wp[2]);
            assign w_rp    = (r_rp[0] & r_rp[1]) | (r_rp[0] & r_rp[2]) | (r_rp[1] & r_rp[2]);
        end else begin : g_single
            assign w_state = r_state[0];
            assign w_wp    = r_wp[0];
            assign w_rp    = r_rp[0];
        end
    endgenerate

    logic [CW-1:0] r_cnt;
    logic [3:0]    r_trigMode;
    logic          r_aborted;
    logic          r_busy;
    logic          r_ready;
    logic          r_rdVld;

    capState_t     w_stateNext;
    logic [AW-1:0] w_wpNext;
    logic [AW-1:0] w_rpNext;
    logic [CW-1:0] w_cntNext;
    logic [3:0]    w_trigModeNext;
    logic          w_abortedNext;
    logic          w_capturing;
    logic          w_we;
    logic          w_rdFire;

    assign w_capturing = (w_state == ST_PRE) || (w_state == ST_ARMED) || (w_state == ST_POST);

    // One counter serves the pre, post and readout phases since they never overlap.
    // A mode change while capturing means the history mixes two mux selections,
    // so it kills the capture even if a trigger lands in the same clock.
    always_comb begin
        w_stateNext    = w_state;
        w_wpNext       = w_wp;
        w_rpNext       = w_rp;
        w_cntNext      = r_cnt;
        w_trigModeNext = r_trigMode;
        w_abortedNext  = r_aborted;
        w_we           = 1'b0;
        w_rdFire       = 1'b0;

        if (w_capturing) begin
            w_we     = 1'b1;
            w_wpNext = w_wp + PTR_ONE;
        end

        if (w_capturing && w_modeChange) begin
            w_stateNext   = ST_IDLE;
            w_abortedNext = 1'b1;
        end else begin
            case (w_state)
                ST_IDLE: begin
                    if (i_arm) begin
                        w_stateNext   = (PRE_LEN == '0) ? ST_ARMED : ST_PRE;
                        w_wpNext      = '0;
                        w_cntNext     = '0;
                        w_abortedNext = 1'b0;
                    end
                end
                ST_PRE: begin
                    if (r_cnt + CNT_ONE >= PRE_LEN) begin
                        w_stateNext = ST_ARMED;
                    end else begin
                        w_cntNext = r_cnt + CNT_ONE;
                    end
                end
                ST_ARMED: begin
                    if (w_trig) begin
                        w_trigModeNext = r_modeB;
                        w_cntNext      = '0;
                        if (POST_LEN == '0) begin
                            w_stateNext = ST_DONE;
                            w_rpNext    = w_wp + PTR_ONE;
                        end else begin
                            w_stateNext = ST_POST;
                        end
                    end
                end
                ST_POST: begin
                    if (r_cnt + CNT_ONE >= POST_LEN) begin
                        w_stateNext = ST_DONE;
                        w_rpNext    = w_wp + PTR_ONE;
                        w_cntNext   = '0;
                    end else begin
                        w_cntNext = r_cnt + CNT_ONE;
                    end
                end
                ST_DONE: begin
                    if (i_arm) begin
                        w_stateNext   = (PRE_LEN == '0) ? ST_ARMED : ST_PRE;
                        w_wpNext      = '0;
                        w_cntNext     = '0;
                        w_abortedNext = 1'b0;
                    end else if (i_rdEn && (r_cnt < RD_LEN)) begin
                        w_rdFire  = 1'b1;
                        w_rpNext  = w_rp + PTR_ONE;
                        w_cntNext = r_cnt + CNT_ONE;
                        if (r_cnt + CNT_ONE >= RD_LEN) begin
                            w_stateNext = ST_IDLE;
                        end
                    end
                end
                default: begin
                    w_stateNext = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstB) begin
            for (int k = 0; k < NCOPY; k++) begin
                r_state[k] <= ST_IDLE;
                r_wp[k]    <= '0;
                r_rp[k]    <= '0;
            end
            r_cnt      <= '0;
            r_trigMode <= '0;
            r_aborted  <= 1'b0;
            r_busy     <= 1'b0;
            r_ready    <= 1'b0;
            r_rdVld    <= 1'b0;
        end else begin
            for (int k = 0; k < NCOPY; k++) begin
                r_state[k] <= w_stateNext;
                r_wp[k]    <= w_wpNext;
                r_rp[k]    <= w_rpNext;
            end
            r_cnt      <= w_cntNext;
            r_trigMode <= w_trigModeNext;
            r_aborted  <= w_abortedNext;
            r_busy     <= (w_stateNext == ST_PRE) || (w_stateNext == ST_ARMED) ||
                          (w_stateNext == ST_POST);
            r_ready    <= (w_stateNext == ST_DONE);
            r_rdVld    <= w_rdFire;
        end
    end

    frontmon_capbuf #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_capbuf (
        .i_clk   (i_clk),
        .i_rstB  (i_rstB),
        .i_we    (w_we),
        .i_waddr (w_wp),
        .i_wdata (r_syncB),
        .i_re    (w_rdFire),
        .i_raddr (w_rp),
        .o_rdata (o_rdData)
    );

    assign o_rdVld    = r_rdVld;
    assign o_busy     = r_busy;
    assign o_ready    = r_ready;
    assign o_aborted  = r_aborted;
    assign o_trigMode = r_trigMode;

endmodule
